// File: rtl/cpu_pkg.sv
// Shared CPU definitions: SRAM arbiter state encoding and grant identifiers.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/sram_io_buf.sv
// 32-bit SRAM data-pin buffer: registered tristate driver plus per-port read capture.
import cpu_pkg::*;

module sram_io_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_oe,
    input  logic        i_load,
    input  logic [31:0] i_wdata,
    input  logic        i_cap_if,
    input  logic        i_cap_dm,
    output logic [31:0] o_if_rdata,
    output logic [31:0] o_dm_rdata,
    inout  wire  [31:0] io_data
);

    logic        r_oe;
    logic [31:0] r_dout;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;

    // Reset releases the bus asynchronously, so an aborted write stops driving at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oe       <= 1'b0;
            r_dout     <= 32'h0;
            r_if_rdata <= 32'h0;
            r_dm_rdata <= 32'h0;
        end else begin
            r_oe <= i_oe;
            if (i_load)   r_dout     <= i_wdata;
            if (i_cap_if) r_if_rdata <= io_data;
            if (i_cap_dm) r_dm_rdata <= io_data;
        end
    end

    assign io_data    = r_oe ? r_dout : 32'hz;
    assign o_if_rdata = r_if_rdata;
    assign o_dm_rdata = r_dm_rdata;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async 32-bit SRAM between fetch and data ports with registered strobes.
// Define SRAM_ARB_RR_EN for round-robin grant; default is fixed data-port priority.
import cpu_pkg::*;

module sram_arbiter #(
    parameter int ADDR_WIDTH  = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [3:0]            dm_be,
    input  logic [31:0]           dm_addr,
    input  logic [31:0]           dm_wdata,
    output logic [31:0]           dm_rdata,
    output logic                  dm_ready,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic [3:0]            sram_be_n,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [31:0]           sram_data
);

    localparam logic [3:0] W_LOAD = 4'(WAIT_CYCLES);

    arb_state_t            r_state;
    logic [3:0]            r_cnt;
    logic                  r_gnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ce_n;
    logic                  r_we_n;
    logic                  r_oe_n;
    logic [3:0]            r_be_n;
    logic                  r_if_ready;
    logic                  r_dm_ready;

    logic                  w_any;
    logic                  w_gnt_nxt;
    logic                  w_we_sel;
    logic [3:0]            w_be_sel;
    logic [31:0]           w_addr_sel;
    logic                  w_last_beat;
    logic                  w_take;
    logic                  w_unused;

`ifdef SRAM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_last <= GNT_IF;
        else if (w_take) r_last <= w_gnt_nxt;
    end
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_gnt_nxt  = GNT_IF;
        w_we_sel   = 1'b0;
        w_be_sel   = 4'h0;
        w_addr_sel = if_addr;
`ifdef SRAM_ARB_RR_EN
        if (if_req && dm_req) w_gnt_nxt = ~r_last;
        else if (dm_req)      w_gnt_nxt = GNT_DM;
`else
        if (dm_req)           w_gnt_nxt = GNT_DM;
`endif
        if (w_gnt_nxt == GNT_DM) begin
            w_we_sel   = dm_we;
            w_be_sel   = dm_be;
            w_addr_sel = dm_addr;
        end
    end

    assign w_any       = if_req | dm_req;
    assign w_take      = (r_state == IDLE) && w_any;
    assign w_last_beat = (r_state == ACCESS) && (r_cnt == 4'd1);
    assign w_unused    = ^{if_addr, dm_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_gnt      <= GNT_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_ce_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_be_n     <= 4'hF;
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= ACCESS;
                        r_gnt   <= w_gnt_nxt;
                        r_we    <= w_we_sel;
                        r_addr  <= w_addr_sel[ADDR_WIDTH+1:2];
                        r_cnt   <= W_LOAD;
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= w_we_sel;
                        r_we_n  <= ~(w_we_sel && (w_be_sel != 4'h0));
                        r_be_n  <= w_we_sel ? ~w_be_sel : 4'h0;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= DONE;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        // Writes keep chip-enable and data for one hold cycle.
                        r_ce_n  <= ~r_we;
                        if (!r_we) r_be_n <= 4'hF;
                        if (r_gnt == GNT_DM) r_dm_ready <= 1'b1;
                        else                 r_if_ready <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ce_n  <= 1'b1;
                    r_be_n  <= 4'hF;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sram_io_buf u_io (
        .clk        (clk),
        .rst        (rst),
        .i_oe       ((w_take && w_we_sel) || ((r_state == ACCESS) && r_we)),
        .i_load     (w_take),
        .i_wdata    (dm_wdata),
        .i_cap_if   (w_last_beat && !r_we && (r_gnt == GNT_IF)),
        .i_cap_dm   (w_last_beat && !r_we && (r_gnt == GNT_DM)),
        .o_if_rdata (if_rdata),
        .o_dm_rdata (dm_rdata),
        .io_data    (sram_data)
    );

    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign sram_ce_n = r_ce_n;
    assign sram_we_n = r_we_n;
    assign sram_oe_n = r_oe_n;
    assign sram_be_n = r_be_n;
    assign sram_addr = r_addr;

endmodule
